// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
// The bit-period divisor truncates, matching integer division of clock by baud.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: reloads on clear, counts down while enabled,
// and pulses tick for one cycle on terminal count.
module uart_baud_tick #(
    parameter int BIT_CYCLES = 434
) (
    input  logic clk_50mhz,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (clear || tick) begin
            cnt <= RELOAD;
        end else if (enable) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_8n1.sv
// Transmit-only 8N1 UART: start bit, eight data bits LSB first, stop bit.
// Outputs are registered from next-state values so the line never glitches.
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_out,
    output logic       tx_busy
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);

    generate
        if (BIT_CYCLES < 2) begin : g_bad_divisor
            $error("uart_tx_8n1: BIT_CYCLES must be at least 2");
        end
    endgenerate

    uart_state_e               state, state_d;
    logic [UART_DATA_BITS-1:0] shreg, shreg_d;
    logic [2:0]                bit_idx, bit_idx_d;
    logic                      tx_out_d, tx_busy_d;
    logic                      accept, tick;

    uart_baud_tick #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .clear     (accept),
        .enable    (state != IDLE),
        .tick      (tick)
    );

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            tx_out  <= UART_IDLE_LEVEL;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_idx <= bit_idx_d;
            tx_out  <= tx_out_d;
            tx_busy <= tx_busy_d;
        end
    end

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_idx_d = bit_idx;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    accept  = 1'b1;
                    shreg_d = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg >> 1;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Drive the line from the state being entered so it lands on the same edge.
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shreg_d[0];
            default: tx_out_d = UART_IDLE_LEVEL;
        endcase
        tx_busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1: frames are decoded at bit centres and
// compared with hand-computed bytes, frame lengths and reset behaviour.
module tb_uart_tx_8n1;

    localparam int B        = 434;
    localparam int FRAME    = 10 * B;
    localparam int CLK_NS   = 20;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       tx_start  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_out;
    logic       tx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_8n1 #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200)) dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy)
    );

    always #(CLK_NS / 2) clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Returns at the first negedge with
    // tx_busy low after the frame. pulse_at > 0 pulses tx_start with 0xA5 mid-frame.
    task automatic send_frame(input logic [7:0] b, input int pulse_at,
                              output int busy_cycles, output realtime span);
        logic [9:0] line;
        logic [7:0] decoded;
        realtime    t_fall;
        int         n;
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk_50mhz);
        tx_start = 1'b0;
        tx_data  = ~b;
        check($sformatf("busy_latency_%02h", b), tx_busy, 1'b1);
        check($sformatf("start_fall_%02h", b), tx_out, 1'b0);
        t_fall      = $realtime;
        busy_cycles = 0;
        line        = '1;
        n           = 1;
        while (tx_busy === 1'b1 && n <= FRAME + 10) begin
            busy_cycles++;
            if ((n % B) == (B / 2) && (n / B) < 10) line[n / B] = tx_out;
            if (pulse_at > 0 && n == pulse_at) begin
                tx_start = 1'b1;
                tx_data  = 8'hA5;
            end
            if (pulse_at > 0 && n == pulse_at + 1) tx_start = 1'b0;
            @(negedge clk_50mhz);
            n++;
        end
        span = $realtime - t_fall;
        check($sformatf("busy_timeout_%02h", b), (n <= FRAME + 10), 1'b1);
        for (int i = 0; i < 8; i++) decoded[i] = line[i + 1];
        check($sformatf("start_bit_%02h", b), line[0], 1'b0);
        check($sformatf("stop_bit_%02h", b), line[9], 1'b1);
        check($sformatf("decode_%02h", b), decoded, b);
    endtask

    int         bc;
    realtime    sp;
    logic [7:0] rnd;

    initial begin
        // Reset with a simultaneous start request: reset must win.
        tx_start = 1'b1;
        tx_data  = 8'h5A;
        repeat (3) @(negedge clk_50mhz);
        check("reset_out", tx_out, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        tx_start = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk_50mhz);
        check("idle_out", tx_out, 1'b1);

        send_frame(8'h55, 0, bc, sp);
        check("len_55", bc, FRAME);

        send_frame(8'h00, 0, bc, sp);
        check("len_00", bc, FRAME);
        repeat (B - 1) @(negedge clk_50mhz);
        check("gap_line", tx_out, 1'b1);
        send_frame(8'hFF, 0, bc, sp);
        check("len_ff", bc, FRAME);

        // Back to back: each start issued on the first idle negedge, so busy is low one cycle.
        for (int k = 0; k < 5; k++) begin
            rnd = 8'($urandom_range(0, 255));
            send_frame(rnd, 0, bc, sp);
            check($sformatf("len_b2b_%0d", k), bc, FRAME);
        end

        // Start pulse mid-frame must be ignored.
        send_frame(8'h3C, 2000, bc, sp);
        check("len_3c", bc, FRAME);
        repeat (2 * B) begin
            @(negedge clk_50mhz);
            if (tx_busy !== 1'b0) break;
        end
        check("no_second_frame", tx_busy, 1'b0);
        check("no_second_line", tx_out, 1'b1);

        // Reset during data bit 3 (fourth bit slot after the start bit).
        tx_data  = 8'hF0;
        tx_start = 1'b1;
        @(negedge clk_50mhz);
        tx_start = 1'b0;
        repeat (4 * B + B / 2 - 1) @(negedge clk_50mhz);
        check("pre_reset_busy", tx_busy, 1'b1);
        check("pre_reset_bit3", tx_out, 1'b0);
        rst_n    = 1'b0;
        tx_start = 1'b1;
        @(negedge clk_50mhz);
        check("midreset_out", tx_out, 1'b1);
        check("midreset_busy", tx_busy, 1'b0);
        rst_n    = 1'b1;
        tx_start = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        check("post_reset_busy", tx_busy, 1'b0);
        send_frame(8'h81, 0, bc, sp);
        check("len_81", bc, FRAME);
        check("span_ns_ok", (sp >= 86800.0 - CLK_NS && sp <= 86800.0 + CLK_NS), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
